corelet_ctrl: RTL and testbench
===============================

Name: corelet_ctrl

Overview:
- Sequencer FSM directly upstream of the corelet.
- Owns the activation/weight SRAM (xmem) read port and the psum SRAM (pmem) write port.
- Drives the corelet's 34-bit instruction bus for one tile: load kernel, stream activations, drain the array, read the output FIFO into pmem.
- One start pulse runs one tile; a done pulse ends it.

Parameters:
- row, 8, MAC array rows (L0 width in words).
- col, 8, MAC array columns.
- addr_w, 11, xmem/pmem address width.
- len_w, 8, width of activation-vector count.

Ports:
- clk  input  1  master clock.
- reset  input  1  master reset; asynchronous, active-high.
- start  input  1  one-cycle request to run a tile; sampled only in IDLE.
- len  input  len_w  number of activation vectors; sampled with start.
- w_base  input  addr_w  xmem address of first kernel word; sampled with start.
- x_base  input  addr_w  xmem address of first activation word; sampled with start.
- p_base  input  addr_w  pmem address of first psum word; sampled with start.
- ofifo_valid  input  1  corelet output FIFO holds a full row.
- inst  output  34  corelet instruction bus.
- xmem_cen  output  1  xmem chip enable, active-low.
- xmem_addr  output  addr_w  xmem read address.
- pmem_wen  output  1  pmem write enable, active-low.
- pmem_addr  output  addr_w  pmem write address.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- inst mapping: bit0 load, bit1 execute, bit2 l0_wr, bit3 l0_rd, bit4 ififo_rd, bit5 ififo_wr, bit6 ofifo_rd. Bits 4, 5, 7-33 are driven 0.
- State register and a phase counter cnt.
- Outputs decode combinationally from state and cnt. The only input-to-output path is ofifo_valid to inst[6] and pmem_wen.
- Reset (asynchronous): state=IDLE, cnt=0, latched config=0. Outputs while in reset: inst=0, xmem_cen=1, pmem_wen=1, addresses 0, busy=0, done=0.
- Reset mid-tile: abort immediately to IDLE. No partial completion or done.
- xmem read latency is 1 cycle, so l0_wr lags the address by one cycle.
- States (cnt restarts at 0 on every state entry):
  - IDLE: on start with len!=0, latch config and go to W_L0. start with len==0 is ignored (no busy, no done).
  - W_L0, cnt 0..row: xmem_cen=0 and xmem_addr=w_base+cnt for cnt<row; l0_wr=1 for cnt>=1. Exit at cnt==row → W_LOAD.
  - W_LOAD, cnt 0..row-1: l0_rd=1, load=1 → W_DRAIN.
  - W_DRAIN, cnt 0..row+col-1: inst=0 → A_L0.
  - A_L0, cnt 0..len: as W_L0 but with x_base and len words → A_EXEC.
  - A_EXEC, cnt 0..len-1: l0_rd=1, execute=1 → A_DRAIN.
  - A_DRAIN, cnt 0..row+col-1: inst=0 → O_READ.
  - O_READ:
    - ofifo_rd = ofifo_valid; pmem_wen = ~ofifo_valid; pmem_addr = p_base + cnt.
    - cnt advances only on a read.
    - After the len-th read → DONE.
    - ofifo_valid low stalls indefinitely with no timeout.
  - DONE: done=1 for one cycle → IDLE.
- start while busy: ignored, not queued.
- Address arithmetic is modulo 2^addr_w; base+offset wraps silently.
- cnt width is max(len_w, clog2(row+col)) + 1; it never saturates within legal len.
- Cycle count, no stalls: (row+1)+row+(row+col)+(len+1)+len+(row+col)+len cycles, then DONE.

Decomposition:
- Shared package corelet_pkg holds:
  - instruction bit index constants (INST_LOAD=0, INST_EXEC=1, INST_L0_WR=2, INST_L0_RD=3, INST_IFIFO_RD=4, INST_IFIFO_WR=5, INST_OFIFO_RD=6, INST_ACC=33, INST_W=34);
  - the state enum ctrl_state_t.
- No sub-module: single FSM plus counter.
- An optional tiny helper, phase_cnt (clearable up-counter with terminal-compare), may be factored out.

Test Plan:
1. row=col=8, len=4, ofifo_valid tied 1, start at edge 0 → busy at edge 1; done high exactly in cycle 63; busy low after. Exactly 8 kernel and 4 activation xmem reads; 4 pmem writes at p_base..p_base+3.
2. Same tile, w_base=0x10, x_base=0x40 → xmem_addr 0x10..0x17 with xmem_cen=0. l0_wr high on the 8 cycles each one cycle later. load and l0_rd high together for 8 cycles. Activation addresses 0x40..0x43 with execute high for 4 cycles.
3. ofifo_valid low for 5 cycles at O_READ entry, then toggling 1,0,1,0... → ofifo_rd and pmem_wen track ofifo_valid exactly. pmem_addr increments only on reads; done one cycle after the 4th read.
4. start with len=0, and start pulsed mid-tile → first stays IDLE with no done. Second has no effect; the tile completes with original config.
5. reset asserted asynchronously during A_EXEC → inst=0, xmem_cen=1, busy=0 without a clock edge. A new start after release runs a full tile correctly.
6. w_base=0x7FC (addr_w=11), row=8 → xmem_addr sequence 0x7FC..0x7FF, 0x000..0x003.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencer: instruction bus bit map,
// controller state encoding and small elaboration-time helpers.
package corelet_pkg;

  localparam int INST_LOAD     = 0;
  localparam int INST_EXEC     = 1;
  localparam int INST_L0_WR    = 2;
  localparam int INST_L0_RD    = 3;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_ACC      = 33;
  localparam int INST_W        = 34;

  typedef enum logic [3:0] {
    IDLE,
    W_L0,
    W_LOAD,
    W_DRAIN,
    A_L0,
    A_EXEC,
    A_DRAIN,
    O_READ,
    DONE
  } ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Tile phases run in a fixed order; IDLE leaves only through the start check.
  function automatic ctrl_state_t next_state(input ctrl_state_t s);
    case (s)
      W_L0:    return W_LOAD;
      W_LOAD:  return W_DRAIN;
      W_DRAIN: return A_L0;
      A_L0:    return A_EXEC;
      A_EXEC:  return A_DRAIN;
      A_DRAIN: return O_READ;
      O_READ:  return DONE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/corelet_ctrl.sv
// Tile sequencer for the corelet: fetches kernel and activations from xmem into L0,
// issues load/execute, waits out the array drain and moves output rows into pmem.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_w-1:0]  len,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] x_base,
  input  logic [addr_w-1:0] p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_addr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = max_int(len_w, $clog2(row + col)) + 1;
  localparam logic [CNT_W-1:0] ROW_C    = CNT_W'(row);
  localparam logic [CNT_W-1:0] ROW_M1   = CNT_W'(row - 1);
  localparam logic [CNT_W-1:0] DRAIN_M1 = CNT_W'(row + col - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ctrl_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [len_w-1:0]  len_q;
  logic [addr_w-1:0] w_q;
  logic [addr_w-1:0] x_q;
  logic [addr_w-1:0] p_q;

  logic [CNT_W-1:0]  len_c;
  logic [CNT_W-1:0]  len_m1;
  logic              last;
  logic              step;

  assign len_c  = CNT_W'(len_q);
  assign len_m1 = len_c - ONE;

  // last: this cycle is the final one of the current phase.
  // step: the phase counter advances this cycle (O_READ only moves on a read).
  always_comb begin
    last = 1'b0;
    step = 1'b1;
    case (state)
      W_L0:             last = (cnt == ROW_C);
      W_LOAD:           last = (cnt == ROW_M1);
      W_DRAIN, A_DRAIN: last = (cnt == DRAIN_M1);
      A_L0:             last = (cnt == len_c);
      A_EXEC:           last = (cnt == len_m1);
      O_READ: begin
        step = ofifo_valid;
        last = ofifo_valid && (cnt == len_m1);
      end
      DONE:             last = 1'b1;
      default:          step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      w_q   <= '0;
      x_q   <= '0;
      p_q   <= '0;
    end else if (state == IDLE) begin
      if (start && (len != '0)) begin
        len_q <= len;
        w_q   <= w_base;
        x_q   <= x_base;
        p_q   <= p_base;
        state <= W_L0;
        cnt   <= '0;
      end
    end else if (last) begin
      state <= next_state(state);
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + ONE;
    end
  end

  // xmem data returns one cycle after the address, so l0_wr trails by one count.
  always_comb begin
    inst      = '0;
    xmem_cen  = 1'b1;
    xmem_addr = '0;
    pmem_wen  = 1'b1;
    pmem_addr = '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      W_L0: begin
        if (cnt < ROW_C) begin
          xmem_cen  = 1'b0;
          xmem_addr = w_q + addr_w'(cnt);
        end
        inst[INST_L0_WR] = (cnt != '0);
      end
      W_LOAD: begin
        inst[INST_LOAD]  = 1'b1;
        inst[INST_L0_RD] = 1'b1;
      end
      A_L0: begin
        if (cnt < len_c) begin
          xmem_cen  = 1'b0;
          xmem_addr = x_q + addr_w'(cnt);
        end
        inst[INST_L0_WR] = (cnt != '0);
      end
      A_EXEC: begin
        inst[INST_EXEC]  = 1'b1;
        inst[INST_L0_RD] = 1'b1;
      end
      O_READ: begin
        inst[INST_OFIFO_RD] = ofifo_valid;
        pmem_wen            = ~ofifo_valid;
        pmem_addr           = p_q + addr_w'(cnt);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: a cycle-indexed tile model drives a per-cycle
// compare, and directed tiles pin latency, address streams and reset behaviour.
module tb_corelet_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int LW  = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic [AW-1:0] w_base;
  logic [AW-1:0] x_base;
  logic [AW-1:0] p_base;
  logic          ofifo_valid;
  logic [33:0]   inst;
  logic          xmem_cen;
  logic [AW-1:0] xmem_addr;
  logic          pmem_wen;
  logic [AW-1:0] pmem_addr;
  logic          busy;
  logic          done;

  corelet_ctrl #(.row(ROW), .col(COL), .addr_w(AW), .len_w(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .w_base(w_base), .x_base(x_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst),
    .xmem_cen(xmem_cen), .xmem_addr(xmem_addr),
    .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A tile is a fixed-length prefix of cycles (indexed by m_t) followed by an
  // O_READ window that lasts until len reads, then a single done cycle.
  int            m_mode = 0;  // 0 idle, 1 tile running, 2 done cycle
  int            m_t = 0;
  int            m_reads = 0;
  int            m_len = 0;
  logic [AW-1:0] m_w = '0;
  logic [AW-1:0] m_x = '0;
  logic [AW-1:0] m_p = '0;

  function automatic int prefix_len(input int l);
    return (ROW + 1) + ROW + (ROW + COL) + (l + 1) + l + (ROW + COL);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= 0;
    end else begin
      case (m_mode)
        0: if (start && len != 0) begin
          m_mode  <= 1;
          m_t     <= 0;
          m_reads <= 0;
          m_len   <= int'(len);
          m_w     <= w_base;
          m_x     <= x_base;
          m_p     <= p_base;
        end
        1: if (m_t < prefix_len(m_len)) begin
          m_t <= m_t + 1;
        end else if (ofifo_valid) begin
          m_reads <= m_reads + 1;
          if (m_reads + 1 == m_len) m_mode <= 2;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [33:0]   e_inst;
    logic          e_cen, e_wen, e_busy, e_done, chk_x, chk_p;
    logic [AW-1:0] e_xa, e_pa;
    int            t;
    e_inst = '0; e_cen = 1'b1; e_wen = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    e_xa = '0; e_pa = '0; chk_x = 1'b0; chk_p = 1'b0;
    t = m_t;
    if (!reset && m_mode == 1) begin
      e_busy = 1'b1;
      if (t < prefix_len(m_len)) begin
        if (t < ROW + 1) begin
          if (t < ROW) begin e_cen = 1'b0; e_xa = m_w + AW'(t); end
          e_inst[2] = (t >= 1);
        end else begin
          t -= ROW + 1;
          if (t < ROW) begin
            e_inst[0] = 1'b1; e_inst[3] = 1'b1;
          end else begin
            t -= ROW + ROW + COL;
            if (t >= 0 && t < m_len + 1) begin
              if (t < m_len) begin e_cen = 1'b0; e_xa = m_x + AW'(t); end
              e_inst[2] = (t >= 1);
            end else if (t >= 0 && t < 2 * m_len + 1) begin
              e_inst[1] = 1'b1; e_inst[3] = 1'b1;
            end
          end
        end
      end else begin
        e_inst[6] = ofifo_valid;
        e_wen     = ~ofifo_valid;
        e_pa      = m_p + AW'(m_reads);
        chk_p     = 1'b1;
      end
    end else if (!reset && m_mode == 2) begin
      e_busy = 1'b1;
      e_done = 1'b1;
    end
    chk_x = ~e_cen;
    check("inst", inst, e_inst);
    check("xmem_cen", xmem_cen, e_cen);
    check("pmem_wen", pmem_wen, e_wen);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    if (chk_x) check("xmem_addr", xmem_addr, e_xa);
    if (chk_p) check("pmem_addr", pmem_addr, e_pa);
  end

  // ---------------- observation logs ----------------
  logic [AW-1:0] x_log[$];
  logic [AW-1:0] p_log[$];
  logic [AW-1:0] exp_q[$];
  int n_load, n_exec, n_l0wr;

  always @(negedge clk) begin
    if (!reset) begin
      if (!xmem_cen) x_log.push_back(xmem_addr);
      if (!pmem_wen) p_log.push_back(pmem_addr);
      n_load += int'(inst[0] & inst[3]);
      n_exec += int'(inst[1]);
      n_l0wr += int'(inst[2]);
    end
  end

  task automatic drain_exp(input string name, input logic [AW-1:0] got[$]);
    int i;
    check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    i = 0;
    while (exp_q.size() > 0) begin
      logic [AW-1:0] e;
      e = exp_q.pop_front();
      if (i < got.size()) check(name, got[i], e);
      i++;
    end
  endtask

  // ---------------- driver ----------------
  // vmode: 0 ofifo_valid tied high, 1 random, 2 low five O_READ cycles then alternating.
  task automatic run_tile(input int l, input logic [AW-1:0] w, input logic [AW-1:0] x,
                          input logic [AW-1:0] p, input int vmode, input int mid_start,
                          input int abort_at, output int done_c);
    int c, j, pre;
    pre = prefix_len(l);
    @(posedge clk); #1;
    x_log.delete(); p_log.delete();
    n_load = 0; n_exec = 0; n_l0wr = 0;
    start = 1'b1; len = LW'(l); w_base = w; x_base = x; p_base = p;
    @(posedge clk); #1;
    start = 1'b0;
    done_c = -1;
    c = 0;
    while (c < 4000) begin
      j = c - pre;
      case (vmode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = 1'($urandom_range(0, 1));
        default: ofifo_valid = (j >= 5) && (((j - 5) % 2) == 0);
      endcase
      if (mid_start != 0 && c == 20) begin
        start  = 1'b1;
        len    = LW'($urandom_range(1, 255));
        w_base = AW'($urandom_range(0, 2047));
        x_base = AW'($urandom_range(0, 2047));
        p_base = AW'($urandom_range(0, 2047));
      end else begin
        start = 1'b0;
      end
      if (c == abort_at) begin
        check("pre_abort_inst", inst, 64'h0a);
        #2 reset = 1'b1;
        #1;
        check("abort_inst", inst, 64'h0);
        check("abort_cen", xmem_cen, 64'h1);
        check("abort_busy", busy, 64'h0);
        check("abort_done", done, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 reset = 1'b0;
        return;
      end
      @(negedge clk);
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    if (done_c < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tile_timeout: got no done after %0d cycles, required done", c);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; len = '0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0;
    #1;
    check("rst_inst", inst, 64'h0);
    check("rst_cen", xmem_cen, 64'h1);
    check("rst_wen", pmem_wen, 64'h1);
    check("rst_xaddr", xmem_addr, 64'h0);
    check("rst_paddr", pmem_addr, 64'h0);
    check("rst_busy", busy, 64'h0);
    check("rst_done", done, 64'h0);
    #11 reset = 1'b0;

    // basic tile, valid tied high
    run_tile(4, 11'h123, 11'h200, 11'h300, 0, 0, -1, dc);
    check("t1_done_cycle", 64'(dc), 64'd62);
    check("t1_busy_after", busy, 64'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(11'h123 + 11'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h200 + 11'(i));
    drain_exp("t1_xaddr", x_log);
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h300 + 11'(i));
    drain_exp("t1_paddr", p_log);

    // address streams and strobe counts
    run_tile(4, 11'h010, 11'h040, 11'h000, 0, 0, -1, dc);
    for (int i = 0; i < 8; i++) exp_q.push_back(11'h010 + 11'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h040 + 11'(i));
    drain_exp("t2_xaddr", x_log);
    check("t2_load_cycles", 64'(n_load), 64'd8);
    check("t2_exec_cycles", 64'(n_exec), 64'd4);
    check("t2_l0wr_cycles", 64'(n_l0wr), 64'd12);

    // stalled output FIFO
    run_tile(4, 11'h000, 11'h100, 11'h050, 2, 0, -1, dc);
    check("t3_done_cycle", 64'(dc), 64'd70);
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h050 + 11'(i));
    drain_exp("t3_paddr", p_log);

    // start with len 0 is ignored
    @(posedge clk); #1; start = 1'b1; len = '0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("len0_busy", busy, 64'h0);
      check("len0_done", done, 64'h0);
    end

    // start while busy is ignored
    run_tile(4, 11'h020, 11'h060, 11'h0a0, 0, 1, -1, dc);
    check("t4_done_cycle", 64'(dc), 64'd62);
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h0a0 + 11'(i));
    drain_exp("t4_paddr", p_log);

    // asynchronous reset during A_EXEC, then a full tile
    run_tile(4, 11'h030, 11'h070, 11'h0b0, 0, 0, 39, dc);
    check("t5_idle_after", busy, 64'h0);
    run_tile(4, 11'h030, 11'h070, 11'h0b0, 0, 0, -1, dc);
    check("t5_done_cycle", 64'(dc), 64'd62);
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h0b0 + 11'(i));
    drain_exp("t5_paddr", p_log);

    // address wrap
    run_tile(3, 11'h7fc, 11'h7fe, 11'h7fe, 0, 0, -1, dc);
    exp_q = '{11'h7fc, 11'h7fd, 11'h7fe, 11'h7ff, 11'h000, 11'h001, 11'h002, 11'h003,
              11'h7fe, 11'h7ff, 11'h000};
    drain_exp("t6_xaddr", x_log);
    exp_q = '{11'h7fe, 11'h7ff, 11'h000};
    drain_exp("t6_paddr", p_log);

    // randomized tiles
    for (int k = 0; k < 8; k++) begin
      int l;
      l = int'($urandom_range(1, 16));
      run_tile(l, AW'($urandom_range(0, 2047)), AW'($urandom_range(0, 2047)),
               AW'($urandom_range(0, 2047)), int'($urandom_range(0, 1)), 0, -1, dc);
      check("rand_writes", 64'(p_log.size()), 64'(l));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
